// File: rtl/rib_arbiter_if.sv
// Handshake bundle between the RIB masters and the RIB arbiter.
// The arbiter uses the slave modport; the master side drives requests and acks.
interface rib_arbiter_if;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic       ack_i;
    logic [3:0] gnt_o;
    logic [1:0] gnt_id_o;
    logic       gnt_valid_o;
    logic       hold_flag_o;
    logic       timeout_o;
    logic [1:0] err_id_o;

    modport master (
        output req_i, lock_i, ack_i,
        input  gnt_o, gnt_id_o, gnt_valid_o, hold_flag_o, timeout_o, err_id_o
    );

    modport slave (
        input  req_i, lock_i, ack_i,
        output gnt_o, gnt_id_o, gnt_valid_o, hold_flag_o, timeout_o, err_id_o
    );
endinterface

// File: rtl/rib_arbiter.sv
// Transaction-holding RIB bus arbiter: m3 has precedence, m0..m2 share round-robin,
// grants are held across locked bursts and reclaimed from hung slaves by a watchdog.
module rib_arbiter #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    rib_arbiter_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [TIMEOUT_W:0]   WD_LIMIT = (TIMEOUT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] WD_MAX   = '1;

    logic [0:0]           state_q, state_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [1:0]           gnt_id_q, gnt_id_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout_q, timeout_d;
    logic [1:0]           err_id_q, err_id_d;

    logic [3:0]           req;
    logic [3:0]           lock;
    logic                 ack;
    logic [1:0]           owner;
    logic [3:0]           owner_mask;
    logic [1:0]           rel_ptr;
    logic [TIMEOUT_W:0]   wd_inc;
    logic                 expire;
    logic                 release_bus;
    logic [2:0]           arb_idle;
    logic [2:0]           arb_rel;

    assign req   = bus.req_i;
    assign lock  = bus.lock_i;
    assign ack   = bus.ack_i;
    assign owner = gnt_id_q;

    // Returns {found, id}. rr_ptr holds the first m0..m2 candidate to try,
    // i.e. the master after the last released owner.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        if (r[3]) begin
            res = 3'b111;
        end else begin
            for (int k = 2; k >= 0; k--) begin
                idx = 2'((int'(start) + k) % 3);
                if (r[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign owner_mask  = 4'b0001 << owner;
    assign rel_ptr     = (owner == 2'd3) ? rr_ptr_q :
                         (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    assign wd_inc      = {1'b0, wd_q} + 1'b1;
    assign expire      = (TIMEOUT_CYCLES != 0) && (state_q == ST_BUSY) && !ack &&
                         (wd_inc >= WD_LIMIT);
    assign release_bus = (ack && !lock[owner]) || !req[owner] || expire;
    assign arb_idle    = arbitrate(req, rr_ptr_q);
    // The releasing owner is masked so it cannot immediately win back the bus.
    assign arb_rel     = arbitrate(req & ~owner_mask, rel_ptr);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        rr_ptr_d  = rr_ptr_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        err_id_d  = err_id_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_idle[2]) begin
                    state_d  = ST_BUSY;
                    gnt_id_d = arb_idle[1:0];
                    gnt_d    = 4'b0001 << arb_idle[1:0];
                    wd_d     = '0;
                end
            end
            default: begin
                if (release_bus) begin
                    rr_ptr_d = rel_ptr;
                    wd_d     = '0;
                    if (expire) begin
                        timeout_d = 1'b1;
                        err_id_d  = owner;
                    end
                    if (arb_rel[2]) begin
                        gnt_id_d = arb_rel[1:0];
                        gnt_d    = 4'b0001 << arb_rel[1:0];
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_id_d = 2'd0;
                        gnt_d    = 4'b0000;
                    end
                end else if (ack) begin
                    wd_d = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            rr_ptr_q  <= 2'd0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            err_id_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            err_id_q  <= err_id_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_id_o    = gnt_id_q;
    assign bus.gnt_valid_o = (state_q == ST_BUSY);
    assign bus.timeout_o   = timeout_q;
    assign bus.err_id_o    = err_id_q;
    // Instruction fetch alone never stalls the pipeline.
    assign bus.hold_flag_o = req[3] | req[2] | req[0] |
                             ((state_q == ST_BUSY) && (gnt_id_q != 2'd1));
endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: an owner/queue-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_rib_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rib_arbiter_if bus ();

    rib_arbiter #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Model: current owner (-1 = none), last released m0..m2 owner, cycles since grant/ack.
    int   m_owner = -1;
    int   m_last  = 2;
    int   m_cnt   = 0;
    int   m_err   = 0;
    bit   m_tout  = 1'b0;
    logic [3:0] m_r, m_l;
    logic       m_a;
    int   m_rel;
    bit   m_expire;
    logic [1:0] m_oi;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int excl, input int last);
        if (r[3] && excl != 3) return 3;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c[1:0]] && c != excl) return c;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_owner = -1; m_last = 2; m_cnt = 0; m_err = 0; m_tout = 1'b0;
            end else begin
                m_r = bus.req_i; m_l = bus.lock_i; m_a = bus.ack_i;
                m_tout = 1'b0;
                if (m_owner < 0) begin
                    m_owner = pick(m_r, -1, m_last);
                    m_cnt   = 0;
                end else begin
                    m_oi     = m_owner[1:0];
                    m_expire = !m_a && (m_cnt + 1 >= TO);
                    if ((m_a && !m_l[m_oi]) || !m_r[m_oi] || m_expire) begin
                        m_rel = m_owner;
                        if (m_expire) begin
                            m_tout = 1'b1;
                            m_err  = m_rel;
                        end
                        if (m_rel != 3) m_last = m_rel;
                        m_owner = pick(m_r, m_rel, m_last);
                        m_cnt   = 0;
                    end else if (m_a) begin
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] eg;
        bit         eh;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                eg = 4'b0000;
                if (m_owner >= 0) eg[m_owner[1:0]] = 1'b1;
                eh = bus.req_i[3] | bus.req_i[2] | bus.req_i[0] | (m_owner >= 0 && m_owner != 1);
                check("cyc_gnt", int'(bus.gnt_o), int'(eg));
                check("cyc_gnt_id", int'(bus.gnt_id_o), (m_owner < 0) ? 0 : m_owner);
                check("cyc_valid", int'(bus.gnt_valid_o), (m_owner >= 0) ? 1 : 0);
                check("cyc_hold", int'(bus.hold_flag_o), int'(eh));
                check("cyc_timeout", int'(bus.timeout_o), int'(m_tout));
                check("cyc_err_id", int'(bus.err_id_o), m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic a);
        bus.req_i  = r;
        bus.lock_i = l;
        bus.ack_i  = a;
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        logic [1:0] rot_ids [7];
        rot_ids = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        drive(4'b0000, 4'b0000, 1'b0);

        // Reset values
        #3 rst = 1'b0;
        #1;
        check("rst_gnt", int'(bus.gnt_o), 0);
        check("rst_gnt_id", int'(bus.gnt_id_o), 0);
        check("rst_valid", int'(bus.gnt_valid_o), 0);
        check("rst_timeout", int'(bus.timeout_o), 0);
        check("rst_err_id", int'(bus.err_id_o), 0);
        cmp_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;

        // Scenario 1: m0 and m2 request, m0 wins after reset
        tick();
        drive(4'b0101, 4'b0000, 1'b0);
        #1 check("s1_hold_pre", int'(bus.hold_flag_o), 1);
        tick();
        check("s1_gnt", int'(bus.gnt_o), 4'b0001);
        check("s1_gnt_id", int'(bus.gnt_id_o), 0);
        check("s1_valid", int'(bus.gnt_valid_o), 1);
        check("s1_hold", int'(bus.hold_flag_o), 1);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // Scenario 2: round-robin rotation, ack every 2nd cycle, no bubbles
        do_reset();
        drive(4'b0111, 4'b0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("s2_rot_id", int'(bus.gnt_id_o), int'(rot_ids[i]));
            check("s2_rot_valid", int'(bus.gnt_valid_o), 1);
            drive(4'b0111, 4'b0000, (i % 2) == 1);
        end
        drive(4'b0000, 4'b0000, 1'b0);
        tick();

        // Scenario 3: locked burst by m0, m3 waits until the unlocked ack
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0);
        tick();
        check("s3_start_id", int'(bus.gnt_id_o), 0);
        for (int b = 0; b < 5; b++) begin
            drive(4'b1001, 4'b0001, (b % 2) == 0);
            tick();
            check("s3_burst_gnt", int'(bus.gnt_o), 4'b0001);
        end
        drive(4'b1001, 4'b0000, 1'b1);
        tick();
        check("s3_m3_gnt", int'(bus.gnt_o), 4'b1000);
        check("s3_m3_id", int'(bus.gnt_id_o), 3);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        check("s3_idle", int'(bus.gnt_valid_o), 0);

        // Scenario 4: watchdog reclaims the bus from m2
        do_reset();
        drive(4'b0100, 4'b0000, 1'b0);
        tick();
        check("s4_gnt_id", int'(bus.gnt_id_o), 2);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("s4_wait_valid", int'(bus.gnt_valid_o), 1);
            check("s4_wait_timeout", int'(bus.timeout_o), 0);
        end
        tick();
        check("s4_rel_gnt", int'(bus.gnt_o), 0);
        check("s4_rel_valid", int'(bus.gnt_valid_o), 0);
        check("s4_timeout", int'(bus.timeout_o), 1);
        check("s4_err_id", int'(bus.err_id_o), 2);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        check("s4_pulse_end", int'(bus.timeout_o), 0);
        check("s4_err_sticky", int'(bus.err_id_o), 2);

        // Scenario 5: ifetch alone never stalls; abort returns to idle
        do_reset();
        drive(4'b0010, 4'b0000, 1'b0);
        #1 check("s5_hold_pre", int'(bus.hold_flag_o), 0);
        tick();
        check("s5_gnt", int'(bus.gnt_o), 4'b0010);
        check("s5_hold", int'(bus.hold_flag_o), 0);
        tick();
        check("s5_hold2", int'(bus.hold_flag_o), 0);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        check("s5_abort_gnt", int'(bus.gnt_o), 0);
        check("s5_abort_valid", int'(bus.gnt_valid_o), 0);

        // Scenario 6: asynchronous reset during an m3 grant
        do_reset();
        drive(4'b1000, 4'b0000, 1'b0);
        tick();
        check("s6_m3_gnt", int'(bus.gnt_o), 4'b1000);
        #2 rst = 1'b0;
        #1;
        check("s6_async_gnt", int'(bus.gnt_o), 0);
        check("s6_async_valid", int'(bus.gnt_valid_o), 0);
        drive(4'b0110, 4'b0000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        check("s6_first_gnt", int'(bus.gnt_o), 4'b0010);
        check("s6_first_id", int'(bus.gnt_id_o), 1);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
